// File: rtl/ext_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_uart_pkg
//  Description : Shared constants for the external-bus UART: register
//                indices, STATUS bit positions, TX/RX state encodings and a
//                helper that clamps a zero divisor to one.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_uart_pkg;

  // Register index, decoded from bus address bits [3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int STAT_RX_NE   = 0;
  localparam int STAT_TX_FULL = 1;
  localparam int STAT_TX_IDLE = 2;
  localparam int STAT_RX_OVR  = 3;

  // TX state encoding
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // RX state encoding
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // A divisor of zero would never expire; treat it as one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous first-word-fall-through FIFO. Pointers carry one
//                extra wrap bit so full and empty are told apart by the MSB.
//                Push and pop in the same cycle are legal at any occupancy,
//                including full (the pop frees the slot the push fills).
//  Ports       : i_clk, i_rst (sync, active high)
//                i_push/i_din  - write side, ignored when full without pop
//                i_pop         - consume o_dout, ignored when empty
//                o_dout        - head entry, valid while o_empty=0
//                o_full/o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   C_PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Storage needs no reset; entries are only read behind the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/ext_uart.sv
`default_nettype none
// ============================================================================
//  Module      : ext_uart
//  Description : 8N1 UART on the external bus with programmable baud divisor
//                and a FIFO in each direction.
//  Ports       : i_clk, i_rst (sync, active high)
//                i_ext_addr/i_ext_stb/i_ext_we/i_ext_dat_w - bus request
//                o_ext_ack/o_ext_dat_r - one-cycle ack with read data
//                i_rx (asynchronous), o_tx (idle high)
//  Registers   : 0 DATA, 1 STATUS, 2 DIVISOR, 3 reads zero
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_uart
  import ext_uart_pkg::*;
#(
  parameter int DIVISOR_RST = 217,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_ext_addr,
  input  logic        i_ext_stb,
  input  logic [3:0]  i_ext_we,
  output logic        o_ext_ack,
  input  logic [31:0] i_ext_dat_w,
  output logic [31:0] o_ext_dat_r,
  input  logic        i_rx,
  output logic        o_tx
);

  localparam logic [15:0] C_DIV_RST = 16'(DIVISOR_RST);

  // ---------------- bus side ----------------
  logic        r_ack;
  logic [31:0] r_dat_r;
  logic [15:0] r_div;
  logic        r_ovr;
  logic        w_access, w_rd, w_wr, w_ovr_clr, w_unused;
  logic [1:0]  w_sel;
  logic [31:0] w_rd_data;
  logic [15:0] w_div_eff, w_rx_half;

  // ---------------- FIFO links ----------------
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0] w_tx_dout;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf;
  logic [7:0] w_rx_dout;

  // ---------------- serial state ----------------
  logic [1:0]  r_tx_state, r_rx_state;
  logic [15:0] r_tx_cnt, r_rx_cnt;
  logic [7:0]  r_tx_shift, r_rx_shift;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic        r_tx;
  logic        r_rx_s1, r_rx_s2, r_rx_d;

  assign w_unused = ^{i_ext_addr[15:4], i_ext_addr[1:0], i_ext_dat_w[31:16], i_ext_we[3:2]};

  // Ack is registered, so a held strobe is seen as a new access only every
  // second cycle; this keeps side effects to one per access.
  assign w_access  = i_ext_stb & ~r_ack;
  assign w_wr      = w_access & (|i_ext_we);
  assign w_rd      = w_access & ~(|i_ext_we);
  assign w_sel     = i_ext_addr[3:2];
  assign w_tx_push = w_wr & (w_sel == REG_DATA) & i_ext_we[0];
  assign w_rx_pop  = w_rd & (w_sel == REG_DATA) & ~w_rx_empty;
  assign w_ovr_clr = w_wr & (w_sel == REG_STATUS) & i_ext_we[0] & i_ext_dat_w[STAT_RX_OVR];

  assign w_div_eff = eff_div(r_div);
  assign w_rx_half = eff_div({1'b0, w_div_eff[15:1]});

  assign o_ext_ack   = r_ack;
  assign o_ext_dat_r = r_dat_r;
  assign o_tx        = r_tx;

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      REG_DATA:   if (!w_rx_empty) w_rd_data = {23'd0, 1'b1, w_rx_dout};
      REG_STATUS: begin
        w_rd_data[STAT_RX_NE]   = ~w_rx_empty;
        w_rd_data[STAT_TX_FULL] = w_tx_full;
        w_rd_data[STAT_TX_IDLE] = w_tx_empty & (r_tx_state == TX_IDLE);
        w_rd_data[STAT_RX_OVR]  = r_ovr;
      end
      REG_DIV:    w_rd_data = {16'd0, r_div};
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack   <= 1'b0;
      r_dat_r <= '0;
      r_div   <= C_DIV_RST;
      r_ovr   <= 1'b0;
    end else begin
      r_ack   <= w_access;
      r_dat_r <= w_rd ? w_rd_data : 32'd0;
      if (w_wr && (w_sel == REG_DIV)) begin
        if (i_ext_we[0]) r_div[7:0]  <= i_ext_dat_w[7:0];
        if (i_ext_we[1]) r_div[15:8] <= i_ext_dat_w[15:8];
      end
      // A fresh overrun wins over a simultaneous clear so it is not lost.
      if (w_rx_ovf)       r_ovr <= 1'b1;
      else if (w_ovr_clr) r_ovr <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  // Pop either from IDLE or at the end of STOP, the latter giving
  // back-to-back frames without an idle bit in between.
  assign w_tx_pop = ~w_tx_empty & ((r_tx_state == TX_IDLE) ||
                                   ((r_tx_state == TX_STOP) && (r_tx_cnt == 16'd0)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (!w_tx_empty) begin
          r_tx_state <= TX_START;
          r_tx_cnt   <= w_div_eff - 16'd1;
          r_tx_shift <= w_tx_dout;
          r_tx       <= 1'b0;
        end
        TX_START: if (r_tx_cnt == 16'd0) begin
          r_tx_state <= TX_DATA;
          r_tx_cnt   <= w_div_eff - 16'd1;
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= 3'd0;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_DATA: if (r_tx_cnt == 16'd0) begin
          r_tx_cnt <= w_div_eff - 16'd1;
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= TX_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_STOP: if (r_tx_cnt == 16'd0) begin
          if (!w_tx_empty) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= w_div_eff - 16'd1;
            r_tx_shift <= w_tx_dout;
            r_tx       <= 1'b0;
          end else r_tx_state <= TX_IDLE;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_cnt == 16'd0) && r_rx_s2;
  // A CPU pop in the same cycle frees a slot, so a full FIFO only overruns
  // when nothing is being read.
  assign w_rx_ovf  = w_rx_push & w_rx_full & ~w_rx_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (!r_rx_s2 && r_rx_d) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= w_rx_half - 16'd1;
        end
        // Re-check the line mid start bit to reject short glitches.
        RX_START: if (r_rx_cnt == 16'd0) begin
          if (!r_rx_s2) begin
            r_rx_state <= RX_DATA;
            r_rx_cnt   <= w_div_eff - 16'd1;
            r_rx_bit   <= 3'd0;
          end else r_rx_state <= RX_IDLE;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_DATA: if (r_rx_cnt == 16'd0) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_cnt   <= w_div_eff - 16'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else                  r_rx_bit   <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_STOP: if (r_rx_cnt == 16'd0) r_rx_state <= RX_IDLE;
                 else r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_tx_push),
    .i_pop  (w_tx_pop),
    .i_din  (i_ext_dat_w[7:0]),
    .o_dout (w_tx_dout),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_rx_push),
    .i_pop  (w_rx_pop),
    .i_din  (r_rx_shift),
    .o_dout (w_rx_dout),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_ext_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_uart
//  Description : Self-checking bench for ext_uart (divisor 4, depth 16).
//                TX bytes are queued when written and compared as frames are
//                decoded off o_tx; RX bytes are queued when driven on i_rx and
//                compared as DATA reads return them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_uart;

  localparam int C_DIV   = 4;
  localparam int C_DEPTH = 16;
  localparam logic [15:0] A_DATA = 16'h0000, A_STAT = 16'h0004,
                          A_DIV  = 16'h0008, A_R3   = 16'h000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ext_addr;
  logic        ext_stb;
  logic [3:0]  ext_we;
  logic        ext_ack;
  logic [31:0] ext_dat_w;
  logic [31:0] ext_dat_r;
  logic        rx;
  logic        tx;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         mon_en = 1'b1;

  always #5 clk = ~clk;

  ext_uart #(.DIVISOR_RST(C_DIV), .FIFO_DEPTH(C_DEPTH)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ext_addr (ext_addr),
    .i_ext_stb  (ext_stb),
    .i_ext_we   (ext_we),
    .o_ext_ack  (ext_ack),
    .i_ext_dat_w(ext_dat_w),
    .o_ext_dat_r(ext_dat_r),
    .i_rx       (rx),
    .o_tx       (tx)
  );

  // One bus access; starts and ends at #1 after a rising edge with ack low.
  task automatic bus_xfer(input logic [15:0] a, input logic [3:0] w,
                          input logic [31:0] d, output logic [31:0] r);
    int n;
    ext_addr = a; ext_we = w; ext_dat_w = d; ext_stb = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!ext_ack && n < 16);
    checks++;
    if (!ext_ack || n != 1)
      begin errors++; $display("FAIL ack_latency: got %0d cycles ack=%0b, want 1 cycle", n, ext_ack); end
    r = ext_dat_r;
    ext_stb = 1'b0; ext_we = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, w, d, dummy);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] r);
    bus_xfer(a, 4'h0, 32'h0, r);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input logic accept);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (accept) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (C_DIV) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (tx_q.size() != 0)
      begin errors++; $display("FAIL tx_drain: %0d frames still pending, want 0", tx_q.size()); end
  endtask

  // Serial TX monitor: samples each bit in its middle on falling edges.
  initial begin : tx_monitor
    logic [7:0] m_got, m_exp;
    logic       m_ok, m_stop;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        m_ok = 1'b1;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) m_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (C_DIV) @(negedge clk);
          m_got[i] = tx;
        end
        repeat (C_DIV) @(negedge clk);
        m_stop = tx;
        checks++;
        if (tx_q.size() == 0) begin
          errors++; $display("FAIL tx_unexpected: got frame 0x%02h, want none", m_got);
        end else begin
          m_exp = tx_q.pop_front();
          if (!m_ok || m_stop !== 1'b1 || m_got !== m_exp)
            begin errors++; $display("FAIL tx_frame: got 0x%02h start_ok=%0b stop=%0b, want 0x%02h", m_got, m_ok, m_stop, m_exp); end
        end
      end
    end
  end

  task automatic test_reset();
    logic [31:0] rd;
    logic [3:0]  acks;
    logic [31:0] d0, d1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || ext_ack !== 1'b0 || ext_dat_r !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: got tx=%0b ack=%0b dat=0x%08h, want 1 0 0", tx, ext_ack, ext_dat_r); end
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL reset_status: got 0x%08h, want 0x4", rd); end
    // Held strobe: one ack every second cycle.
    ext_addr = A_STAT; ext_we = 4'h0; ext_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acks[i] = ext_ack;
      if (i == 0) d0 = ext_dat_r;
      if (i == 1) d1 = ext_dat_r;
    end
    ext_stb = 1'b0;
    checks++;
    if (acks !== 4'b0101) begin errors++; $display("FAIL held_strobe_acks: got %b, want 0101", acks); end
    checks++;
    if (d0 !== 32'h4 || d1 !== 32'h0)
      begin errors++; $display("FAIL held_strobe_data: got 0x%08h/0x%08h, want 0x4/0x0", d0, d1); end
    @(posedge clk); #1;
  endtask

  task automatic test_divisor();
    logic [31:0] rd;
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL div_reset: got 0x%08h, want 0x4", rd); end
    bus_write(A_DIV, 4'b0011, 32'hDEAD_1234);
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'h1234) begin errors++; $display("FAIL div_write: got 0x%08h, want 0x1234", rd); end
    bus_write(A_DIV, 4'b0001, 32'h0000_FFAB);
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'h12AB) begin errors++; $display("FAIL div_byte_en: got 0x%08h, want 0x12AB", rd); end
    bus_write(A_R3, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_R3, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reg3_read: got 0x%08h, want 0x0", rd); end
    bus_write(A_DIV, 4'b0011, 32'd4);
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL div_restore: got 0x%08h, want 0x4", rd); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] rd;
    logic [9:0]  fr;
    fr = {1'b1, 8'h55, 1'b0};
    tx_q.push_back(8'h55);
    bus_write(A_DATA, 4'h1, 32'h55);
    // Start bit is already on the line one cycle after the write is acked.
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (tx !== fr[i/4])
        begin errors++; $display("FAIL tx_wave[%0d]: got %0b, want %0b", i, tx, fr[i/4]); end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_frame: got %0b, want 1", tx); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL tx_idle_after: got 0x%08h, want 0x4", rd); end
    tx_q.push_back(8'hC3);
    bus_write(A_DATA, 4'h1, 32'hC3);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL tx_busy_status: got 0x%08h, want 0x0", rd); end
    wait_tx_drain();
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL tx_idle_again: got 0x%08h, want 0x4", rd); end
  endtask

  task automatic test_rx_single();
    logic [31:0] rd, ex;
    send_rx(8'hA3, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL rx_status: got 0x%08h, want 0x5", rd); end
    bus_read(A_DATA, rd);
    ex = 32'h0;
    if (rx_q.size() != 0) ex = {23'd0, 1'b1, rx_q.pop_front()};
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL rx_data: got 0x%08h, want 0x%08h", rd, ex); end
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rx_empty_read: got 0x%08h, want 0x0", rd); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd, ex;
    for (int i = 0; i < C_DEPTH + 1; i++)
      send_rx(8'h30 + 8'(i), 1'b1, (i < C_DEPTH));
    repeat (6) @(posedge clk);
    #1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'hD) begin errors++; $display("FAIL ovr_status: got 0x%08h, want 0xD", rd); end
    for (int i = 0; i < C_DEPTH + 1; i++) begin
      bus_read(A_DATA, rd);
      ex = 32'h0;
      if (rx_q.size() != 0) ex = {23'd0, 1'b1, rx_q.pop_front()};
      checks++;
      if (rd !== ex) begin errors++; $display("FAIL ovr_data[%0d]: got 0x%08h, want 0x%08h", i, rd, ex); end
    end
    bus_write(A_STAT, 4'h1, 32'h8);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL ovr_clear: got 0x%08h, want 0x4", rd); end
  endtask

  task automatic test_rx_glitch_framing();
    logic [31:0] rd;
    send_rx(8'h5A, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL rx_glitch_framing: got 0x%08h, want 0x4", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    // First byte is popped at once; the next 16 fill the FIFO long before
    // the first frame ends, so the 18th is dropped.
    for (int k = 0; k < C_DEPTH + 2; k++) begin
      if (k < C_DEPTH + 1) tx_q.push_back(8'h80 + 8'(k));
      bus_write(A_DATA, 4'h1, 32'h80 + k);
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL tx_full_status: got 0x%08h, want 0x2", rd); end
    wait_tx_drain();
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL b2b_idle: got 0x%08h, want 0x4", rd); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] rd;
    bit          low_seen;
    mon_en = 1'b0;
    bus_write(A_DATA, 4'h1, 32'h00);
    bus_write(A_DATA, 4'h1, 32'h01);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame_low: got %0b, want 0", tx); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_high: got %0b, want 1", tx); end
    rst = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    checks++;
    if (low_seen) begin errors++; $display("FAIL reset_tx_fifo_flushed: got activity on tx, want idle"); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL reset_mid_status: got 0x%08h, want 0x4", rd); end
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_rx: got 0x%08h, want 0x0", rd); end
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ext_addr = '0; ext_stb = 1'b0; ext_we = '0; ext_dat_w = '0; rx = 1'b1;
    test_reset();
    test_divisor();
    test_tx_frame();
    test_rx_single();
    test_rx_overrun();
    test_rx_glitch_framing();
    test_back_to_back();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_uart.md
Name: ext_uart

Overview:
- UART peripheral on the SoC external bus (address window 0x2000_0000; the peripheral sees the bus-local 16-bit address).
- Consumes the external bus strobe/write-enable/data signals and returns read data and ack.
- Provides 8N1 serial TX/RX with a programmable baud divisor and a small FIFO in each direction, so polled CPU software does not lose bytes.

Parameters:
- DIVISOR_RST, 217, reset value of the baud divisor (clocks per bit; 25 MHz / 115200).
- FIFO_DEPTH, 16, entries per FIFO; must be a power of two, minimum 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_ext_addr  in  16  bus-local byte address; only bits [3:2] are decoded
- i_ext_stb  in  1  access request, held by the master until ack
- i_ext_we  in  4  byte write enables; 0 means read
- o_ext_ack  out  1  one-cycle access acknowledge
- i_ext_dat_w  in  32  write data
- o_ext_dat_r  out  32  read data, valid while o_ext_ack=1
- i_rx  in  1  serial input (asynchronous)
- o_tx  out  1  serial output, idle high

Behaviour:
- Reset values:
  - o_ext_ack=0, o_ext_dat_r=0, o_tx=1.
  - Both FIFOs empty, divisor=DIVISOR_RST, overrun=0, TX and RX FSMs in IDLE.
  - Reset mid-frame aborts the frame; o_tx returns high on the next cycle.
- Bus handshake:
  - Define access = i_ext_stb & ~o_ext_ack.
  - o_ext_ack is registered: o_ext_ack <= access. Latency is exactly 1 cycle.
  - A held strobe produces one ack every 2 cycles. Side effects happen once per access.
  - All side effects (push, pop, register write) occur in the access cycle.
  - o_ext_dat_r is registered in the same cycle and is zero when no access is in progress.
- Register map, selected by addr[3:2]:
  - 0 DATA
    - Write with we[0]: push dat_w[7:0] into the TX FIFO. If the FIFO is full the byte is dropped; the access is still acked.
    - Read: returns {23'b0, valid, byte}. When the RX FIFO is non-empty, valid=1 and one entry is popped. When empty, the read returns 0 and nothing is popped.
  - 1 STATUS (read-only except bit3)
    - bit0 rx_not_empty
    - bit1 tx_full
    - bit2 tx_idle (TX FIFO empty and TX FSM in IDLE)
    - bit3 rx_overrun (sticky)
    - Writing 1 to bit3 with we[0] clears rx_overrun.
  - 2 DIVISOR: bits [15:0] read/write. Writes honour we[0] and we[1]. A new value takes effect at the next bit boundary.
  - 3: reads 0; writes are ignored.
- TX FSM: IDLE -> START -> DATA(x8, LSB first) -> STOP -> IDLE.
  - Each state lasts DIVISOR clocks, counted with a 16-bit down-counter.
  - In IDLE with the FIFO non-empty: pop in that cycle, drive the start bit the next cycle.
  - Back-to-back frames have no idle gap.
  - A divisor value of 0 is treated as 1.
- RX:
  - i_rx passes through a 2-flop synchroniser.
  - IDLE: on a falling edge go to START and wait DIVISOR/2 clocks.
    - If the line is still low, go to DATA.
    - Otherwise, a glitch: return to IDLE.
  - DATA samples 8 bits, one every DIVISOR clocks. STOP samples once more.
  - Stop bit = 1: push the byte. If the FIFO is full, drop the byte and set rx_overrun.
  - Stop bit = 0 (framing error): discard the byte; no status flag.
- Simultaneous events:
  - RX push and CPU pop in the same cycle on a full FIFO: both succeed, no overrun.
  - TX FSM pop and CPU push on a full TX FIFO: the CPU push is accepted.
  - FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty are derived from the pointer MSB comparison.

Decomposition:
- Package ext_uart_pkg:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_DIV=2
  - status bit positions
  - TX/RX state enums
- Sub-module uart_fifo, instantiated twice.
  - Parameters: WIDTH=8, DEPTH.
  - Signals: push, pop, din, dout (first-word fall-through), full, empty.
  - Simultaneous push and pop is legal at any occupancy.

Test Plan:
- Reset, DIVISOR_RST=4 -> read STATUS returns 0x4; o_tx=1; ack arrives exactly 1 cycle after stb.
- Write DATA 0x55 -> o_tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks (40 clocks total); STATUS bit2 is 0 during the frame and 1 afterwards.
- Drive 0xA3 on i_rx at the divisor rate -> STATUS bit0=1; read DATA returns 0x1A3; a second read returns 0x000.
- Send 17 frames with FIFO_DEPTH=16 without reading -> STATUS bit3=1; the first 16 bytes read back in order; write 0x8 to STATUS clears bit3.
- Write 17 bytes to DATA back-to-back -> tx_full is observed; the 17th byte is dropped unless the TX FSM has already popped one; the serial output order is preserved.
- 1-clock low glitch on i_rx -> no byte received. Assert i_rst mid-TX-frame -> o_tx=1 on the next cycle and all FIFOs are empty.
